// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bridge_pkg : shared types and access-size encodings for the     |
// |                  data-port load/store bridge                        |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

endpackage : mem_bridge_pkg
`default_nettype wire

// File: rtl/data_mem_bridge_lane_steer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lane_steer : byte-enable generation and store-data lane replication |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module lane_steer
    import mem_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  byteenable,
    output logic [31:0] steered_data,
    output logic        misaligned
);

    // Data is replicated across lanes so the slave picks it up on whichever
    // lane the byte enables select; no per-offset shifter is needed.
    always_comb begin
        byteenable   = 4'b0000;
        steered_data = 32'h0000_0000;
        misaligned   = 1'b0;
        case (size)
            SZ_BYTE: begin
                byteenable   = 4'b0001 << offset;
                steered_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byteenable   = offset[1] ? 4'b1100 : 4'b0011;
                steered_data = {2{wdata[15:0]}};
                misaligned   = offset[0];
            end
            SZ_WORD: begin
                byteenable   = 4'b1111;
                steered_data = wdata;
                misaligned   = |offset;
            end
            default: begin
                byteenable   = 4'b0000;
                steered_data = 32'h0000_0000;
                misaligned   = 1'b0;
            end
        endcase
    end

endmodule : lane_steer
`default_nettype wire

// File: rtl/data_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_bridge : load/store bridge from the core data port to an  |
// |                   Avalon-style bus; stalls the core until done     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_writedata,
    output logic              stall,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    output logic              bus_write,
    output logic [3:0]        bus_byteenable,
    output logic [DATA_W-1:0] bus_writedata,
    input  logic              bus_waitrequest,
    input  logic [DATA_W-1:0] bus_readdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] bus_address_q, bus_address_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic [3:0]        bus_byteenable_q, bus_byteenable_d;
    logic [DATA_W-1:0] bus_writedata_q, bus_writedata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_readdata_q, rsp_readdata_d;

    logic [3:0]        steer_be;
    logic [DATA_W-1:0] steer_data;
    logic              steer_misaligned;
    logic              req_any;
    logic              req_illegal;

    lane_steer u_lane_steer (
        .size         (req_size),
        .offset       (req_address[1:0]),
        .wdata        (req_writedata),
        .byteenable   (steer_be),
        .steered_data (steer_data),
        .misaligned   (steer_misaligned)
    );

    assign req_any     = req_read | req_write;
    assign req_illegal = (req_read & req_write) | (req_size == SZ_ILLEGAL) | steer_misaligned;

    // Combinational so the core freezes in the very cycle a request appears.
    assign stall = (state_q == ISSUE) | ((state_q == IDLE) & req_any);

    always_comb begin
        state_d          = state_q;
        bus_address_d    = bus_address_q;
        bus_read_d       = bus_read_q;
        bus_write_d      = bus_write_q;
        bus_byteenable_d = bus_byteenable_q;
        bus_writedata_d  = bus_writedata_q;
        rsp_readdata_d   = rsp_readdata_q;
        rsp_valid_d      = 1'b0;
        rsp_error_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (req_illegal) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d          = ISSUE;
                        bus_address_d    = {req_address[ADDR_W-1:2], 2'b00};
                        bus_read_d       = req_read;
                        bus_write_d      = req_write;
                        bus_byteenable_d = steer_be;
                        bus_writedata_d  = steer_data;
                    end
                end
            end
            ISSUE: begin
                if (!bus_waitrequest) begin
                    state_d     = DONE;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (bus_read_q) begin
                        rsp_readdata_d = bus_readdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            bus_address_q    <= '0;
            bus_read_q       <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_byteenable_q <= 4'b0000;
            bus_writedata_q  <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_error_q      <= 1'b0;
            rsp_readdata_q   <= '0;
        end else begin
            state_q          <= state_d;
            bus_address_q    <= bus_address_d;
            bus_read_q       <= bus_read_d;
            bus_write_q      <= bus_write_d;
            bus_byteenable_q <= bus_byteenable_d;
            bus_writedata_q  <= bus_writedata_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_error_q      <= rsp_error_d;
            rsp_readdata_q   <= rsp_readdata_d;
        end
    end

    assign bus_address    = bus_address_q;
    assign bus_read       = bus_read_q;
    assign bus_write      = bus_write_q;
    assign bus_byteenable = bus_byteenable_q;
    assign bus_writedata  = bus_writedata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_readdata   = rsp_readdata_q;

endmodule : data_mem_bridge
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_mem_bridge : directed self-checking bench for the bridge   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_data_mem_bridge;
    import mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_writedata;
    logic        stall, rsp_valid, rsp_error;
    logic [31:0] rsp_readdata, bus_address, bus_writedata, bus_readdata;
    logic        bus_read, bus_write, bus_waitrequest;
    logic [3:0]  bus_byteenable;

    always #5 clk = ~clk;

    data_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_address     (req_address),
        .req_writedata   (req_writedata),
        .stall           (stall),
        .rsp_valid       (rsp_valid),
        .rsp_error       (rsp_error),
        .rsp_readdata    (rsp_readdata),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_byteenable  (bus_byteenable),
        .bus_writedata   (bus_writedata),
        .bus_waitrequest (bus_waitrequest),
        .bus_readdata    (bus_readdata)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle, set by the stimulus tasks
    logic        exp_stall, exp_rd, exp_wr, exp_valid, exp_err;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [3:0]  exp_be;
    bit          chk_on = 1'b0, chk_bus = 1'b0, chk_wd = 1'b0;

    // Reference state: last completed read word
    logic [31:0] m_rdata;

    // Snapshots for hand-computed literal expectations
    logic [31:0] issue_addr, issue_wd, done_rdata;
    logic [3:0]  issue_be;
    logic        done_valid, done_err;
    logic [7:0]  hist;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic m_err(input logic rd, input logic wr, input logic [1:0] size,
                                   input logic [1:0] k);
        return (rd && wr) || (size == 2'd3) || ((int'(k) % nbytes(size)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] k);
        int m;
        m = ((1 << nbytes(size)) - 1) << k;
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % nbytes(size)) +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("bus_read", 32'(bus_read), 32'(exp_rd));
            chk("bus_write", 32'(bus_write), 32'(exp_wr));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("rsp_error", 32'(rsp_error), 32'(exp_err));
            chk("rsp_readdata", rsp_readdata, exp_rdata);
            if (chk_bus) begin
                chk("bus_address", bus_address, exp_addr);
                chk("bus_byteenable", 32'(bus_byteenable), 32'(exp_be));
                if (chk_wd) chk("bus_writedata", bus_writedata, exp_wd);
            end
        end
    end

    task automatic set_quiet();
        exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = m_rdata;
        chk_bus = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_read = 1'b0; req_write = 1'b0;
            set_quiet();
        end
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int nwait, input logic [31:0] rdata);
        logic bad;
        bad  = m_err(rd, wr, size, addr[1:0]);
        hist = 8'h00;
        @(posedge clk); #1;
        req_read = rd; req_write = wr; req_size = size;
        req_address = addr; req_writedata = wdata;
        bus_waitrequest = 1'b1; bus_readdata = 32'h0BAD_0BAD;
        set_quiet();
        exp_stall = 1'b1;
        @(negedge clk); hist = {hist[6:0], stall};
        if (!bad) begin
            for (int i = 0; i <= nwait; i++) begin
                @(posedge clk); #1;
                bus_waitrequest = (i < nwait);
                bus_readdata    = (i < nwait) ? (32'h0BAD_0BAD ^ 32'(i)) : rdata;
                exp_stall = 1'b1; exp_rd = rd; exp_wr = wr;
                exp_valid = 1'b0; exp_err = 1'b0;
                exp_addr  = {addr[31:2], 2'b00};
                exp_be    = m_be(size, addr[1:0]);
                exp_wd    = m_wd(size, wdata);
                chk_bus = 1'b1; chk_wd = wr;
                @(negedge clk); hist = {hist[6:0], stall};
                if (i == 0) begin
                    issue_addr = bus_address; issue_be = bus_byteenable; issue_wd = bus_writedata;
                end
            end
        end
        // Request inputs stay asserted through DONE; the bridge must ignore them.
        @(posedge clk); #1;
        bus_waitrequest = 1'b0;
        if (rd && !bad) m_rdata = rdata;
        set_quiet();
        exp_valid = 1'b1; exp_err = bad;
        @(negedge clk); hist = {hist[6:0], stall};
        done_valid = rsp_valid; done_err = rsp_error; done_rdata = rsp_readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_read = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_address = 32'h0; req_writedata = 32'h0;
        bus_waitrequest = 1'b0; bus_readdata = 32'h0;
        m_rdata = 32'h0;
        set_quiet();
        exp_addr = 32'h0; exp_be = 4'h0; exp_wd = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk_bus = 1'b1; chk_wd = 1'b1; chk_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        run_txn(1'b0, 1'b1, SZ_WORD, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0);
        chk("t1_addr", issue_addr, 32'h0000_1004);
        chk("t1_be", 32'(issue_be), 32'h0000_000F);
        chk("t1_wd", issue_wd, 32'hDEAD_BEEF);
        chk("t1_stall_pattern", 32'(hist[2:0]), 32'h0000_0006);
        chk("t1_valid", 32'(done_valid), 32'h1);
        idle(1);

        run_txn(1'b1, 1'b0, SZ_BYTE, 32'h0000_2003, 32'h0, 2, 32'hAABB_CCDD);
        chk("t2_be", 32'(issue_be), 32'h0000_0008);
        chk("t2_addr", issue_addr, 32'h0000_2000);
        chk("t2_rdata", done_rdata, 32'hAABB_CCDD);
        chk("t2_stall_pattern", 32'(hist[4:0]), 32'h0000_001E);

        run_txn(1'b0, 1'b1, SZ_HALF, 32'h0000_0012, 32'h0000_1234, 1, 32'h0);
        chk("t3_be", 32'(issue_be), 32'h0000_000C);
        chk("t3_wd", issue_wd, 32'h1234_1234);
        idle(1);

        run_txn(1'b1, 1'b0, SZ_WORD, 32'h0000_3002, 32'h0, 0, 32'h1111_1111);
        chk("t4_err", 32'(done_err), 32'h1);
        chk("t4_valid", 32'(done_valid), 32'h1);
        chk("t4_stall_pattern", 32'(hist[1:0]), 32'h0000_0002);
        chk("t4_rdata_kept", done_rdata, 32'hAABB_CCDD);

        run_txn(1'b1, 1'b1, SZ_WORD, 32'h0000_0100, 32'h5555_5555, 0, 32'h2222_2222);
        chk("t5_rw_err", 32'(done_err), 32'h1);
        run_txn(1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0, 0, 32'h3333_3333);
        chk("t6_size_err", 32'(done_err), 32'h1);
        run_txn(1'b0, 1'b1, SZ_HALF, 32'h0000_0051, 32'h0000_7777, 0, 32'h0);
        chk("t6b_half_misalign_err", 32'(done_err), 32'h1);

        run_txn(1'b0, 1'b1, SZ_BYTE, 32'h0000_0041, 32'h0000_00A5, 0, 32'h0);
        chk("t7_be", 32'(issue_be), 32'h0000_0002);
        chk("t7_wd", issue_wd, 32'hA5A5_A5A5);
        run_txn(1'b1, 1'b0, SZ_HALF, 32'h0000_0050, 32'h0, 1, 32'h5566_7788);
        chk("t8_rdata", done_rdata, 32'h5566_7788);
        chk("t8_be", 32'(issue_be), 32'h0000_0003);
        idle(1);

        // Reset while ISSUE is stuck on waitrequest
        @(posedge clk); #1;
        req_read = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_address = 32'h0000_4000;
        bus_waitrequest = 1'b1;
        set_quiet();
        exp_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                reset = 1'b0; req_read = 1'b0;
            end
            exp_stall = 1'b1; exp_rd = 1'b1; exp_wr = 1'b0;
            exp_addr = 32'h0000_4000; exp_be = 4'hF;
            chk_bus = 1'b1; chk_wd = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_rdata = 32'h0;
        set_quiet();
        exp_addr = 32'h0; exp_be = 4'h0; exp_wd = 32'h0;
        chk_bus = 1'b1; chk_wd = 1'b1;
        idle(2);

        run_txn(1'b1, 1'b0, SZ_WORD, 32'h0000_0060, 32'h0, 0, 32'h0F0F_0F0F);
        chk("t10_rdata", done_rdata, 32'h0F0F_0F0F);
        idle(2);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_mem_bridge
`default_nettype wire
